// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC egress arbiter.
// Imported by noc_rr_picker and noc_egress_arbiter.
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int CRED_W = 4;
    localparam int STAT_W = 16;

    localparam int REQ_GPU    = 0;
    localparam int REQ_SPINE1 = 1;
    localparam int REQ_SPINE2 = 2;
    localparam int REQ_SPINE3 = 3;
    localparam int REQ_SPINE4 = 4;

    // A simultaneous pop and return cancel out; a return at full count is dropped.
    function automatic logic [CRED_W-1:0] credit_update(
        input logic [CRED_W-1:0] cur,
        input logic              take,
        input logic              give,
        input logic [CRED_W-1:0] max_cred
    );
        logic [CRED_W-1:0] res;
        res = cur;
        if (take && !give) begin
            res = cur - CRED_W'(1);
        end else if (give && !take && (cur != max_cred)) begin
            res = cur + CRED_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping around to the lowest index when nothing at or above the pointer is valid.
module noc_rr_picker
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_valid
);

    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] masked_low;
    logic [NUM_REQ-1:0] plain_low;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked[gi] = req_valid[gi] && (PTR_W'(gi) >= rr_ptr);
        end
    endgenerate

    // x & -x isolates the lowest set bit
    assign masked_low = masked & (~masked + NUM_REQ'(1));
    assign plain_low  = req_valid & (~req_valid + NUM_REQ'(1));

    assign winner    = (|masked) ? masked_low : plain_low;
    assign any_valid = |req_valid;

endmodule

// File: rtl/noc_egress_arbiter.sv
// Credit-based round-robin egress scheduler for one router output port.
// Optional per-requester flit counters are enabled with NOC_ARB_STATS_EN.
module noc_egress_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ   = 5,
    parameter int DWIDTH    = 16,
    parameter int CREDITS   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       arb_enable,
    input  logic [NUM_REQ*DWIDTH-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DWIDTH-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       credit_return,
    output logic [CRED_W-1:0]          credit_count,
    output logic [NUM_REQ-1:0]         current_grant,
    output logic                       busy,
    output logic [NUM_REQ*STAT_W-1:0]  grant_count
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int BURST_W = 4;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [CRED_W-1:0]  CRED_MAX   = CRED_W'(CREDITS);

    arb_state_e          state_reg, state_next;
    logic [NUM_REQ-1:0]  grant_reg;
    logic [PTR_W-1:0]    rr_ptr_reg;
    logic [BURST_W-1:0]  burst_reg;
    logic [CRED_W-1:0]   credit_reg;
    logic [DWIDTH-1:0]   out_data_reg;
    logic                out_valid_reg;

    logic [NUM_REQ-1:0]  winner;
    logic                any_valid;
    logic                has_credit;
    logic                grant_valid;
    logic                xfer;
    logic                start;
    logic                release_now;
    logic [DWIDTH-1:0]   sel_data;
    logic [DWIDTH-1:0]   sel_terms [NUM_REQ];
    logic [PTR_W-1:0]    ptr_after_grant;

    noc_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign has_credit  = (credit_reg != '0);
    assign grant_valid = |(req_valid & grant_reg);
    assign xfer        = (state_reg == ARB_GRANT) && grant_valid && has_credit;
    assign start       = (state_reg == ARB_IDLE) && arb_enable && any_valid && has_credit;
    // A credit stall (valid but no credit) keeps the grant; only these end it.
    assign release_now = (state_reg == ARB_GRANT) &&
                         ((xfer && (burst_reg == BURST_LAST)) || !grant_valid || !arb_enable);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign sel_terms[gi] = grant_reg[gi] ? req_data[gi*DWIDTH +: DWIDTH] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | sel_terms[i];
        end
    end

    always_comb begin
        ptr_after_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_reg[i]) begin
                ptr_after_grant = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:  if (start)       state_next = ARB_GRANT;
            ARB_GRANT: if (release_now) state_next = ARB_IDLE;
            default:                    state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_reg == ARB_GRANT) begin
            busy = 1'b1;
            if (xfer) begin
                req_ready = grant_reg;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_reg     <= '0;
            credit_reg    <= CRED_MAX;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (start) begin
                grant_reg <= winner;
                burst_reg <= '0;
            end else begin
                if (release_now) begin
                    grant_reg  <= '0;
                    rr_ptr_reg <= ptr_after_grant;
                end
                if (xfer) begin
                    burst_reg <= burst_reg + BURST_W'(1);
                end
            end
            credit_reg    <= credit_update(credit_reg, xfer, credit_return, CRED_MAX);
            out_valid_reg <= xfer;
            if (xfer) begin
                out_data_reg <= sel_data;
            end
        end
    end

    assign out_data      = out_data_reg;
    assign out_valid     = out_valid_reg;
    assign credit_count  = credit_reg;
    assign current_grant = grant_reg;

`ifdef NOC_ARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [STAT_W-1:0] stat_reg;
            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    stat_reg <= '0;
                end else if (req_ready[gi] && (stat_reg != '1)) begin
                    stat_reg <= stat_reg + STAT_W'(1);
                end
            end
            assign grant_count[gi*STAT_W +: STAT_W] = stat_reg;
        end
    endgenerate
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_noc_egress_arbiter.sv
// Directed bench for noc_egress_arbiter: per-cycle vector table plus hand-written
// reset, round-robin (MAX_BURST=1 instance) and counter sequences.
module tb_noc_egress_arbiter;
    import noc_arb_pkg::*;

    localparam int N  = 5;
    localparam int DW = 16;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    always #5 ACLK = ~ACLK;

    // main instance (MAX_BURST = 4)
    logic              arb_enable;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              credit_return;
    logic [CRED_W-1:0] credit_count;
    logic [N-1:0]      current_grant;
    logic              busy;
    logic [N*STAT_W-1:0] grant_count;

    // round-robin instance (MAX_BURST = 1)
    logic              rr_en;
    logic [N*DW-1:0]   rr_data;
    logic [N-1:0]      rr_valid;
    logic [N-1:0]      rr_ready;
    logic [DW-1:0]     rr_out_data;
    logic              rr_out_valid;
    logic              rr_cret;
    logic [CRED_W-1:0] rr_credit;
    logic [N-1:0]      rr_grant;
    logic              rr_busy;
    logic [N*STAT_W-1:0] rr_gcount;

    noc_egress_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .CREDITS(4), .MAX_BURST(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .arb_enable(arb_enable),
        .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .out_data(out_data), .out_valid(out_valid), .credit_return(credit_return),
        .credit_count(credit_count), .current_grant(current_grant), .busy(busy),
        .grant_count(grant_count)
    );

    noc_egress_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .CREDITS(4), .MAX_BURST(1)) dut_rr (
        .ACLK(ACLK), .ARESETn(ARESETn), .arb_enable(rr_en),
        .req_data(rr_data), .req_valid(rr_valid), .req_ready(rr_ready),
        .out_data(rr_out_data), .out_valid(rr_out_valid), .credit_return(rr_cret),
        .credit_count(rr_credit), .current_grant(rr_grant), .busy(rr_busy),
        .grant_count(rr_gcount)
    );

    // Inputs applied during a cycle and the state visible in that same cycle.
    typedef struct {
        logic          en;
        logic [N-1:0]  valid;
        logic          cret;
        logic [9:0]    lo;
        logic [N-1:0]  e_rdy;
        logic          e_ov;
        logic [15:0]   e_od;
        logic [N-1:0]  e_grant;
        logic          e_busy;
        logic [3:0]    e_cred;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic en, logic [N-1:0] valid, logic cret, logic [9:0] lo,
                                logic [N-1:0] e_rdy, logic e_ov, logic [15:0] e_od,
                                logic [N-1:0] e_grant, logic e_busy, logic [3:0] e_cred);
        vec_t v;
        v.en = en; v.valid = valid; v.cret = cret; v.lo = lo;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od;
        v.e_grant = e_grant; v.e_busy = e_busy; v.e_cred = e_cred;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_data(input logic [9:0] lo);
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = {6'(i + 1), lo};
        end
    endtask

    initial begin
        ARESETn = 1'b0; arb_enable = 1'b0; req_valid = '0; credit_return = 1'b0;
        req_data = '0;
        rr_en = 1'b0; rr_valid = '0; rr_cret = 1'b0;
        for (int i = 0; i < N; i++) rr_data[i*DW +: DW] = 16'hA000 | 16'(i);

        //           en  valid     cr lo     rdy       ov od       grant     bsy cred
        vq.push_back(mk(1, 5'b00001, 0, 10'd1, 5'b00000, 0, 16'h0000, 5'b00000, 0, 4)); // c0
        vq.push_back(mk(1, 5'b00001, 0, 10'd1, 5'b00001, 0, 16'h0000, 5'b00001, 1, 4));
        vq.push_back(mk(1, 5'b00001, 0, 10'd2, 5'b00001, 1, 16'h0401, 5'b00001, 1, 3));
        vq.push_back(mk(1, 5'b00001, 0, 10'd3, 5'b00001, 1, 16'h0402, 5'b00001, 1, 2));
        vq.push_back(mk(1, 5'b00001, 0, 10'd4, 5'b00001, 1, 16'h0403, 5'b00001, 1, 1));
        vq.push_back(mk(1, 5'b00001, 0, 10'd5, 5'b00000, 1, 16'h0404, 5'b00000, 0, 0)); // c5
        vq.push_back(mk(1, 5'b00000, 1, 10'd5, 5'b00000, 0, 16'h0404, 5'b00000, 0, 0));
        vq.push_back(mk(1, 5'b00100, 0, 10'd1, 5'b00000, 0, 16'h0404, 5'b00000, 0, 1));
        vq.push_back(mk(1, 5'b00100, 0, 10'd1, 5'b00100, 0, 16'h0404, 5'b00100, 1, 1));
        vq.push_back(mk(1, 5'b00100, 0, 10'd2, 5'b00000, 1, 16'h0C01, 5'b00100, 1, 0));
        vq.push_back(mk(1, 5'b00100, 1, 10'd2, 5'b00000, 0, 16'h0C01, 5'b00100, 1, 0)); // c10
        vq.push_back(mk(1, 5'b00100, 0, 10'd2, 5'b00100, 0, 16'h0C01, 5'b00100, 1, 1));
        vq.push_back(mk(1, 5'b00100, 1, 10'd3, 5'b00000, 1, 16'h0C02, 5'b00100, 1, 0));
        vq.push_back(mk(1, 5'b00100, 1, 10'd3, 5'b00100, 0, 16'h0C02, 5'b00100, 1, 1));
        vq.push_back(mk(1, 5'b00000, 0, 10'd3, 5'b00000, 1, 16'h0C03, 5'b00100, 1, 1));
        vq.push_back(mk(1, 5'b00000, 1, 10'd3, 5'b00000, 0, 16'h0C03, 5'b00000, 0, 1)); // c15
        vq.push_back(mk(1, 5'b00000, 1, 10'd3, 5'b00000, 0, 16'h0C03, 5'b00000, 0, 2));
        vq.push_back(mk(1, 5'b00000, 1, 10'd3, 5'b00000, 0, 16'h0C03, 5'b00000, 0, 3));
        vq.push_back(mk(1, 5'b00000, 1, 10'd3, 5'b00000, 0, 16'h0C03, 5'b00000, 0, 4));
        vq.push_back(mk(1, 5'b00011, 0, 10'd7, 5'b00000, 0, 16'h0C03, 5'b00000, 0, 4));
        vq.push_back(mk(0, 5'b00011, 0, 10'd7, 5'b00001, 0, 16'h0C03, 5'b00001, 1, 4)); // c20
        vq.push_back(mk(1, 5'b00011, 0, 10'd8, 5'b00000, 1, 16'h0407, 5'b00000, 0, 3));
        vq.push_back(mk(1, 5'b00011, 0, 10'd8, 5'b00010, 0, 16'h0407, 5'b00010, 1, 3));
        vq.push_back(mk(1, 5'b00011, 0, 10'd8, 5'b00010, 1, 16'h0808, 5'b00010, 1, 2));

        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_credit", 32'(credit_count), 32'd4);
        chk("reset_grant", 32'(current_grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        ARESETn = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            @(posedge ACLK);
            #1;
            arb_enable    = vq[k].en;
            req_valid     = vq[k].valid;
            credit_return = vq[k].cret;
            drive_data(vq[k].lo);
            @(negedge ACLK);
            chk($sformatf("v%0d_req_ready", k), 32'(req_ready), 32'(vq[k].e_rdy));
            chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(vq[k].e_ov));
            chk($sformatf("v%0d_out_data", k), 32'(out_data), 32'(vq[k].e_od));
            chk($sformatf("v%0d_grant", k), 32'(current_grant), 32'(vq[k].e_grant));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vq[k].e_busy));
            chk($sformatf("v%0d_credit", k), 32'(credit_count), 32'(vq[k].e_cred));
`ifdef NOC_ARB_STATS_EN
            if (k == 6) chk("stats_gpu_after_burst", 32'(grant_count[15:0]), 32'd4);
`else
            chk($sformatf("v%0d_grant_count", k), 32'(grant_count[31:0] | grant_count[79:32]), 32'd0);
`endif
            $display("vec %0d: grant=%b rdy=%b ov=%b od=%h cred=%0d", k,
                     current_grant, req_ready, out_valid, out_data, credit_count);
        end

        // reset asserted mid-burst takes effect without a clock edge
        ARESETn = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_out_data", 32'(out_data), 32'd0);
        chk("midreset_grant", 32'(current_grant), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_ready", 32'(req_ready), 32'd0);
        chk("midreset_credit", 32'(credit_count), 32'd4);
        $display("mid-burst reset: grant=%b cred=%0d", current_grant, credit_count);
        arb_enable = 1'b0; req_valid = '0; credit_return = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;

        // round-robin: all valid, one flit per grant, credit back every cycle
        @(posedge ACLK);
        #1;
        rr_en = 1'b1; rr_valid = 5'b11111; rr_cret = 1'b1;
        for (int j = 0; j < 12; j++) begin
            logic [N-1:0] exp_g;
            exp_g = (j % 2 == 1) ? N'(1 << (((j - 1) / 2) % N)) : '0;
            @(negedge ACLK);
            chk($sformatf("rr%0d_grant", j), 32'(rr_grant), 32'(exp_g));
            chk($sformatf("rr%0d_busy", j), 32'(rr_busy), 32'(j % 2));
            chk($sformatf("rr%0d_credit", j), 32'(rr_credit), 32'd4);
            $display("rr cycle %0d: grant=%b busy=%b cred=%0d", j, rr_grant, rr_busy, rr_credit);
        end
`ifdef NOC_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rr_stats_%0d", i), 32'(rr_gcount[i*STAT_W +: STAT_W]), 32'd1);
        end
`else
        chk("rr_grant_count_zero", 32'(rr_gcount[31:0] | rr_gcount[79:32]), 32'd0);
`endif
        rr_valid = '0; rr_en = 1'b0; rr_cret = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
